// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants, FSM state type and address decode for the register-file write arbiter.
package rf_pkg;

  localparam int RF_NREG = 8;
  localparam int RF_AW   = 3;
  localparam int RF_DW   = 32;
  localparam int RF_NREQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Turns a register address into the one-hot enable the register file expects.
  function automatic logic [RF_NREG-1:0] onehot8(input logic [RF_AW-1:0] addr);
    onehot8 = RF_NREG'(1) << addr;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of requester-side and register-file-side signals around the write arbiter.
interface rf_write_arbiter_if;
  import rf_pkg::*;

  logic [RF_NREQ-1:0]       req;
  logic [RF_NREQ*RF_AW-1:0] wr_addr;
  logic [RF_NREQ*RF_DW-1:0] wr_data;
  logic [RF_NREQ-1:0]       ack;
  logic                     clr_start;
  logic                     clr_busy;
  logic [RF_NREG-1:0]       en;
  logic [RF_DW-1:0]         d_in;

  // Requester / controller side: drives requests and clear pulses, sees grants and the write port.
  modport master (
    output req, wr_addr, wr_data, clr_start,
    input  ack, clr_busy, en, d_in
  );

  // Arbiter side.
  modport slave (
    input  req, wr_addr, wr_data, clr_start,
    output ack, clr_busy, en, d_in
  );

endinterface

// File: rtl/rf_write_arbiter_rr_arbiter4.sv
// Combinational 4-way round-robin pick: first set request at or above the pointer, wrapping.
module rr_arbiter4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [3:0] o_grant,
  output logic [1:0] o_winner
);

  logic [1:0] w_idx;
  logic       w_found;

  // Walk the four slots starting at the pointer and grant the first requester found.
  always_comb begin
    o_grant  = '0;
    o_winner = i_ptr;
    w_found  = 1'b0;
    w_idx    = i_ptr;
    for (int k = 0; k < 4; k++) begin
      w_idx = i_ptr + 2'(k);
      if (!w_found && i_req[w_idx]) begin
        w_found         = 1'b1;
        o_winner        = w_idx;
        o_grant[w_idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Write-port controller for the 8x32 register file: round-robin writes plus a sequenced clear.
module rf_write_arbiter
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  rf_write_arbiter_if.slave bus
);

  state_t             r_state,  w_nextState;
  logic [RF_AW-1:0]   r_clrCnt, w_nextClrCnt;
  logic [1:0]         r_rrPtr,  w_nextRrPtr;
  logic [RF_NREG-1:0] r_en,     w_nextEn;
  logic [RF_DW-1:0]   r_dIn,    w_nextDIn;

  logic [RF_NREQ-1:0] w_grant;
  logic [RF_NREQ-1:0] w_ack;
  logic [1:0]         w_winner;
  logic [RF_AW-1:0]   w_winAddr;
  logic [RF_DW-1:0]   w_winData;

  rr_arbiter4 u_arb (
    .i_req    (bus.req),
    .i_ptr    (r_rrPtr),
    .o_grant  (w_grant),
    .o_winner (w_winner)
  );

  assign w_winAddr = bus.wr_addr[int'(w_winner)*RF_AW +: RF_AW];
  assign w_winData = bus.wr_data[int'(w_winner)*RF_DW +: RF_DW];

  // Next-state and grant logic; a clear request beats pending writes and holds them off.
  always_comb begin
    w_nextState  = r_state;
    w_nextClrCnt = r_clrCnt;
    w_nextRrPtr  = r_rrPtr;
    w_nextEn     = '0;
    w_nextDIn    = r_dIn;
    w_ack        = '0;
    case (r_state)
      IDLE: begin
        if (bus.clr_start) begin
          w_nextState  = CLEAR;
          w_nextClrCnt = '0;
        end else if (|bus.req) begin
          w_ack       = reset_n ? w_grant : '0;
          w_nextEn    = onehot8(w_winAddr);
          w_nextDIn   = w_winData;
          w_nextRrPtr = w_winner + 2'd1;
        end
      end
      CLEAR: begin
        w_nextEn     = onehot8(r_clrCnt);
        w_nextDIn    = '0;
        w_nextClrCnt = r_clrCnt + 3'd1;
        if (r_clrCnt == 3'(RF_NREG-1)) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State, pointer, clear counter and registered write port; reset aborts any clear in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_clrCnt <= '0;
      r_rrPtr  <= '0;
      r_en     <= '0;
      r_dIn    <= '0;
    end else begin
      r_state  <= w_nextState;
      r_clrCnt <= w_nextClrCnt;
      r_rrPtr  <= w_nextRrPtr;
      r_en     <= w_nextEn;
      r_dIn    <= w_nextDIn;
    end
  end

  assign bus.ack      = w_ack;
  assign bus.clr_busy = (r_state == CLEAR);
  assign bus.en       = r_en;
  assign bus.d_in     = r_dIn;

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-port controller for the 8 x 32-bit register file (`register32_8`). It shares the file's single one-hot-enabled write port between four requesters using round-robin arbitration. It also provides a sequenced clear operation that zeroes all eight registers. Its `en`/`d_in` outputs connect directly to the register file's `en`/`d_in` inputs, and it shares the register file's `clk`/`reset_n`.

## Interface
- `N_REQ`, 4 — number of requesters (fixed at 4 in this revision)
- `DW`, 32 — data width
- `NREG`, 8 — number of registers; the address width is 3
- `clk`  in  1  — system clock, rising-edge
- `reset_n`  in  1  — asynchronous, active-low reset
- `req`  in  4  — per-requester write request; level, held until acked
- `wr_addr`  in  12  — requester i's address is bits [3i+2:3i]
- `wr_data`  in  128  — requester i's data is bits [32i+31:32i]
- `ack`  out  4  — combinational one-hot grant; the write is accepted on a rising edge where `ack[i]`=1
- `clr_start`  in  1  — single-cycle pulse that requests a full clear
- `clr_busy`  out  1  — high while the clear sequence is running
- `en`  out  8  — registered one-hot write enable to the register file
- `d_in`  out  32  — registered write data to the register file

## Operation
- The FSM has two states, IDLE and CLEAR. Reset enters IDLE.
- **IDLE, normal writes:**
  - If `clr_start`=0 and any `req` is set, grant the first requester with `req` set, searching from `rr_ptr` upward with wrap-around.
  - `ack` is one-hot on the winner and 0 when nothing is requested.
  - On the clock edge: `en` <= onehot(winner addr) and `d_in` <= winner data.
  - `rr_ptr` <= (winner+1) mod 4.
- **IDLE, no request:** on the edge, `en` <= 0. `d_in` holds its previous value.
- **IDLE, clear start:** if `clr_start`=1, clear has priority. `ack` = 0 that cycle; requests stay pending. On the edge: state <= CLEAR, `clr_cnt` <= 0, `en` <= 0.
- **CLEAR:**
  - Each cycle, on the edge: `en` <= onehot(`clr_cnt`), `d_in` <= 0, `clr_cnt` increments.
  - After the `clr_cnt`=7 write is issued, state <= IDLE.
  - `ack` = 0 for the whole of CLEAR. `clr_start` is ignored.
- `clr_busy` = (state == CLEAR).
- `rr_ptr` is unchanged by a clear.
- `en` is always one-hot or zero; it is never multi-hot.
- **Reset values:** `en`=0, `d_in`=0, `ack`=0, `clr_busy`=0, `rr_ptr`=0, state=IDLE, `clr_cnt`=0.

## Timing
- **Write latency:**
  - Cycle t: `req`, `ack` high, accept edge at the end of t.
  - Cycle t+1: `en`/`d_in` valid.
  - The register file captures the data on the edge at the end of t+1.
- **Throughput:** one write per cycle. Back-to-back grants to different requesters are allowed.
- **Fairness:** a requester that holds `req` continuously is acked within 4 IDLE cycles.
- **Clear sequence:** `clr_start` in cycle t, then `clr_busy`=1 in cycles t+1 through t+8. `en` = 8'h01, 8'h02, …, 8'h80 in cycles t+2 through t+9. The first request ack can occur in cycle t+9.
- **Simultaneous `clr_start` and `req`:** the clear wins and the request waits.
- **Reset mid-operation:** asynchronous assertion immediately forces `en`=0 and `ack`=0, and aborts any clear. A partially written register file is not restored.
- **Requester rule:** a requester must not drop `req` or change its addr/data while `ack` is low. Dropping `req` before ack is a protocol violation; behaviour in that case is undefined except that `en` stays at most one-hot.

## Structure
- Shared package `rf_pkg`:
  - constants `RF_NREG`=8, `RF_AW`=3, `RF_DW`=32
  - state enum {IDLE, CLEAR}
  - a `onehot8(addr)` decode function
- One sub-module, `rr_arbiter4`: a combinational 4-way round-robin priority pick (inputs `req` and `ptr`; outputs one-hot grant and winner index).
- The FSM, pointer, clear counter and output registers live in the top level.

## Test plan
- **Reset:** hold `reset_n`=0 with `req`=4'hF → `en`=0, `d_in`=0, `ack`=0. Release reset → first ack=4'b0001.
- **Single write:** `req`[2]=1, addr=5, data=32'h00FF00FF → `ack`=4'b0100 that cycle; next cycle `en`=8'h20, `d_in`=32'h00FF00FF; register 5 reads 32'h00FF00FF.
- **Round-robin:** all four requests held, each dropping after its ack → acks in order 0,1,2,3 on consecutive cycles, with `en`/`d_in` following one cycle later. Then re-raise `req`[0] and `req`[3] → ack goes to 0, because `rr_ptr` wrapped to 0.
- **Clear:** preload registers with 32'hA5A5A5A5, pulse `clr_start` → `clr_busy` high for 8 cycles, `en` walks 8'h01 to 8'h80 with `d_in`=0, all registers read 0.
- **Clear contention:** `clr_start` and `req`[1] in the same cycle → no ack during the clear; `ack`[1] is asserted in the first cycle after `clr_busy` falls. A second `clr_start` during CLEAR has no effect.
- **Reset mid-clear:** assert `reset_n`=0 after the third clear write → `en`=0 immediately, `clr_busy`=0, registers 3–7 keep their old values (register file is reset too if on the shared reset).
